// File: rtl/adc_scan_sequencer.sv
// ADC128S102 scan sequencer: walks an 8-channel mask, issues conv_go/addr, tags results.
// Optional 4x averaging per channel when ADC_SCAN_AVG_EN is defined.
module adc_scan_sequencer #(
  parameter int unsigned SCAN_GAP    = 1000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic [7:0]  ch_mask,
  input  logic        err_clr,
  output logic        conv_go,
  output logic [2:0]  addr,
  input  logic [11:0] adc_data,
  input  logic        adc_conv_done,
  output logic        busy,
  output logic        res_valid,
  output logic [2:0]  res_ch,
  output logic [11:0] res_data,
  output logic        scan_done,
  output logic        timeout_err
);

  localparam int unsigned CNT_MAX = (SCAN_GAP > TIMEOUT_CYC) ? SCAN_GAP : TIMEOUT_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SCAN_GAP - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_FIND, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t        state;
  logic [7:0]    m_reg;
  logic [3:0]    ch_ptr;
  logic [CW-1:0] cnt;
  logic [7:0]    avail;
  logic          found;
  logic [2:0]    next_ch;
  logic [3:0]    ptr_after;

`ifdef ADC_SCAN_AVG_EN
  logic [1:0]    scnt;
  logic [13:0]   acc;
  logic [13:0]   acc_sum;

  always_comb acc_sum = acc + {2'b00, adc_data};
`endif

  // ch_ptr == 8 shifts the whole window out, so nothing is found
  always_comb begin
    avail     = m_reg & (8'hFF << ch_ptr);
    found     = 1'b0;
    next_ch   = '0;
    ptr_after = {1'b0, addr} + 4'd1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (avail[7 - i]) begin
        found   = 1'b1;
        next_ch = 3'(7 - i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      m_reg       <= '0;
      ch_ptr      <= '0;
      cnt         <= '0;
      conv_go     <= 1'b0;
      addr        <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_data    <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      scnt        <= '0;
      acc         <= '0;
`endif
    end else begin
      conv_go   <= 1'b0;
      res_valid <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // scan_done is still high on the first IDLE cycle; a start there is dropped
          if (start && !scan_done && ch_mask != '0) begin
            m_reg  <= ch_mask;
            ch_ptr <= '0;
            busy   <= 1'b1;
            state  <= S_FIND;
          end
        end
        S_FIND: begin
          if (found) begin
            addr    <= next_ch;
            conv_go <= 1'b1;
            state   <= S_ISSUE;
`ifdef ADC_SCAN_AVG_EN
            scnt    <= '0;
            acc     <= '0;
`endif
          end else begin
            scan_done <= 1'b1;
            cnt       <= '0;
            if (cont) begin
              state <= S_GAP;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (adc_conv_done) begin
`ifdef ADC_SCAN_AVG_EN
            if (scnt == 2'd3) begin
              res_valid <= 1'b1;
              res_ch    <= addr;
              res_data  <= acc_sum[13:2];
              ch_ptr    <= ptr_after;
              state     <= S_FIND;
            end else begin
              acc     <= acc_sum;
              scnt    <= scnt + 2'd1;
              conv_go <= 1'b1;
              state   <= S_ISSUE;
            end
`else
            res_valid <= 1'b1;
            res_ch    <= addr;
            res_data  <= adc_data;
            ch_ptr    <= ptr_after;
            state     <= S_FIND;
`endif
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            ch_ptr      <= ptr_after;
            state       <= S_FIND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            if (cont && ch_mask != '0) begin
              m_reg  <= ch_mask;
              ch_ptr <= '0;
              state  <= S_FIND;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: behavioural ADC driver plus result scoreboard.
module tb_adc_scan_sequencer;
  localparam int unsigned SCAN_GAP    = 10;
  localparam int unsigned TIMEOUT_CYC = 255;
  localparam int          LAT         = 72;

  logic        clk = 1'b0;
  logic        rst_n, start, cont, err_clr;
  logic [7:0]  ch_mask;
  logic        conv_go, busy, res_valid, scan_done, timeout_err;
  logic [2:0]  addr, res_ch;
  logic [11:0] adc_data, res_data;
  logic        adc_conv_done;

  int          total = 0;
  int          bad = 0;
  int          go_cnt = 0, res_cnt = 0, done_cnt = 0, unexpected = 0;
  int          cyc = 0;
  logic [7:0]  silent = 8'h00;
  logic [14:0] sb[$];
  logic [14:0] sb_e;
  logic [2:0]  cur;
  logic        dead;

  adc_scan_sequencer #(.SCAN_GAP(SCAN_GAP), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .ch_mask(ch_mask),
    .err_clr(err_clr), .conv_go(conv_go), .addr(addr), .adc_data(adc_data),
    .adc_conv_done(adc_conv_done), .busy(busy), .res_valid(res_valid),
    .res_ch(res_ch), .res_data(res_data), .scan_done(scan_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_mask(input logic [7:0] m);
    for (int i = 0; i < 8; i++)
      if (m[i] && !silent[i]) sb.push_back({3'(i), 12'h100 + 12'(i)});
  endtask

  task automatic pulse_start(input logic [7:0] m);
    ch_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_done !== 1'b1 && n < budget);
    chk(tag, 32'(scan_done), 1);
  endtask

  task automatic wait_go(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (conv_go !== 1'b1 && n < budget);
    chk(tag, 32'(conv_go), 1);
  endtask

  // Behavioural ADC driver: answers LAT cycles after conv_go with 0x100+channel
  initial begin
    adc_conv_done = 1'b0;
    adc_data      = '0;
    forever begin
      @(negedge clk);
      if (conv_go === 1'b1) begin
        cur  = addr;
        dead = 1'b0;
        for (int k = 0; k < LAT; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) dead = 1'b1;
          if (!dead) chk("addr_stable", 32'(addr), 32'(cur));
        end
        if (!silent[cur]) begin
          adc_data      = 12'h100 + 12'(cur);
          adc_conv_done = 1'b1;
          @(negedge clk);
          adc_conv_done = 1'b0;
          adc_data      = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (conv_go === 1'b1) go_cnt++;
    if (scan_done === 1'b1) done_cnt++;
    if (res_valid === 1'b1) begin
      res_cnt++;
      if (sb.size() == 0) begin
        unexpected++;
      end else begin
        sb_e = sb.pop_front();
        chk("res_ch", 32'(res_ch), 32'(sb_e[14:12]));
        chk("res_data", 32'(res_data), 32'(sb_e[11:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_go, snap_res, snap_done, n, t1, t2;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; ch_mask = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_conv_go", 32'(conv_go), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_res_ch", 32'(res_ch), 0);
    chk("rst_res_data", 32'(res_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single scan of channels 0, 2, 7
    push_mask(8'b1000_0101);
    pulse_start(8'b1000_0101);
    chk("find_busy", 32'(busy), 1);
    chk("find_no_go", 32'(conv_go), 0);
    @(negedge clk);
    chk("go_latency", 32'(conv_go), 1);
    chk("first_addr", 32'(addr), 0);
    wait_done(1000, "single_scan_done");
    pulse_start(8'b1000_0101);
    chk("start_on_done_ignored", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("single_busy_end", 32'(busy), 0);
    chk("single_res_count", 32'(res_cnt), 3);
    chk("single_go_count", 32'(go_cnt), 3);
    chk("single_sb_empty", 32'(sb.size()), 0);

    // empty mask
    snap_go = go_cnt; snap_res = res_cnt; snap_done = done_cnt;
    pulse_start(8'h00);
    chk("empty_busy0", 32'(busy), 0);
    repeat (20) @(negedge clk);
    chk("empty_busy1", 32'(busy), 0);
    chk("empty_no_go", 32'(go_cnt - snap_go), 0);
    chk("empty_no_res", 32'(res_cnt - snap_res), 0);
    chk("empty_no_done", 32'(done_cnt - snap_done), 0);

    // timeout on channel 0, channel 1 still converts
    silent   = 8'h01;
    snap_res = res_cnt;
    push_mask(8'h03);
    pulse_start(8'h03);
    wait_go(10, "to_conv_go");
    n = 0;
    while (timeout_err !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", 32'(n), TIMEOUT_CYC + 1);
    wait_done(600, "to_scan_done");
    repeat (2) @(negedge clk);
    chk("timeout_sticky", 32'(timeout_err), 1);
    chk("timeout_res_count", 32'(res_cnt - snap_res), 1);
    chk("timeout_sb_empty", 32'(sb.size()), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 32'(timeout_err), 0);
    silent = 8'h00;

    // continuous mode: spacing, then cont drop mid-scan gives one final scan
    cont = 1'b1;
    push_mask(8'h01);
    pulse_start(8'h01);
    wait_done(500, "cont_done1");
    t1 = cyc;
    push_mask(8'h01);
    wait_done(500, "cont_done2");
    t2 = cyc;
    chk("cont_spacing", 32'(t2 - t1), SCAN_GAP + LAT + 3);
    push_mask(8'h01);
    repeat (16) @(negedge clk);
    chk("cont_rescan_busy", 32'(busy), 1);
    cont = 1'b0;
    wait_done(500, "cont_done3");
    repeat (3) @(negedge clk);
    chk("cont_idle", 32'(busy), 0);
    snap_go = go_cnt;
    repeat (120) @(negedge clk);
    chk("cont_stopped", 32'(go_cnt - snap_go), 0);
    chk("cont_sb_empty", 32'(sb.size()), 0);

    // async reset during WAIT; the late conv_done must be ignored
    pulse_start(8'h04);
    wait_go(10, "rst_conv_go_seen");
    snap_res = res_cnt; snap_done = done_cnt;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_addr", 32'(addr), 0);
    chk("async_res_ch", 32'(res_ch), 0);
    chk("async_res_data", 32'(res_data), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("late_done_no_res", 32'(res_cnt - snap_res), 0);
    chk("late_done_no_scan", 32'(done_cnt - snap_done), 0);
    chk("late_done_busy", 32'(busy), 0);
    chk("unexpected_res", 32'(unexpected), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Control stage directly upstream of the ADC128S102 serial driver. It walks a mask of the 8 input channels and issues one-cycle conv_go requests with a stable 3-bit addr.
- It captures each 12-bit result during the driver's one-cycle conv_done pulse and presents it to the user as a tagged result pulse.
- Supports single-shot and continuous scanning, with a conversion timeout watchdog.

Parameters:
- SCAN_GAP, 1000: idle clocks between consecutive scans in continuous mode (minimum 1).
- TIMEOUT_CYC, 255: clocks to wait for conv_done after conv_go before the channel is abandoned (must exceed the driver's roughly 72-clock conversion).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a scan when idle
- cont  in  1  level; 1 = rescan after SCAN_GAP, sampled at end of each scan
- ch_mask  in  8  channel enable bits, bit i = channel i; sampled at scan start
- err_clr  in  1  clears timeout_err
- conv_go  out  1  one-cycle conversion request to driver
- addr  out  3  channel select to driver, held stable from conv_go until conv_done or timeout
- adc_data  in  12  driver result, valid only while adc_conv_done = 1
- adc_conv_done  in  1  driver result strobe
- busy  out  1  high in every state except IDLE
- res_valid  out  1  one-cycle result strobe
- res_ch  out  3  channel of res_data, held until next res_valid
- res_data  out  12  result, held until next res_valid
- scan_done  out  1  one-cycle pulse after the last enabled channel is handled
- timeout_err  out  1  sticky, set on any timeout

Behaviour:
- Reset (async) values:
  - conv_go, res_valid, scan_done, timeout_err, busy = 0.
  - addr, res_ch, res_data = 0.
  - State = IDLE; all counters = 0.
- All outputs are registered.
- Reset mid-scan aborts immediately. A driver conversion still in flight is ignored: adc_conv_done is honoured only in WAIT.
- FSM IDLE:
  - On start=1 with ch_mask≠0: latch mask into m_reg, set ch_ptr=0, go to FIND.
  - On start=1 with ch_mask=0: stay in IDLE; no pulses are produced.
  - start in any other state is ignored.
- FSM FIND:
  - Scan m_reg from ch_ptr upward for the lowest set bit.
  - If found: addr<=that index, go to ISSUE.
  - If none is left: scan_done<=1 for one cycle. Then go to GAP if cont=1, else IDLE.
  - Takes 1 cycle (combinational priority encode).
- FSM ISSUE:
  - conv_go=1 for exactly this one cycle.
  - Clear the timeout counter, go to WAIT.
  - Result: conv_go rises 2 clocks after the start pulse.
- FSM WAIT: addr is held.
  - On adc_conv_done=1: capture adc_data.
  - Next cycle: res_valid=1, res_ch=addr, res_data=captured value. Set ch_ptr=addr+1 and go to FIND.
  - If the counter reaches TIMEOUT_CYC first: set timeout_err, emit no res_valid, set ch_ptr=addr+1, go to FIND.
  - If adc_conv_done and timeout occur on the same cycle, adc_conv_done wins and there is no error.
- FSM GAP:
  - Count SCAN_GAP clocks, then relatch ch_mask. Go to FIND if the mask is nonzero, else IDLE.
  - If cont falls during GAP, go to IDLE at the end of the gap without rescanning.
- ch_ptr is 4 bits. ch_ptr=8 means no channels remain; addr+1 from channel 7 gives 8, not 0.
- err_clr takes priority over a simultaneous timeout set (timeout_err is cleared).
- Back-to-back scans:
  - A start pulse on the same cycle as scan_done is ignored.
  - start is accepted only while in IDLE.

Optional Feature:
- Macro: ADC_SCAN_AVG_EN.
- Defined:
  - Each enabled channel is converted 4 times consecutively (ISSUE/WAIT repeated).
  - Results are summed in a 14-bit accumulator.
  - res_data = sum[13:2] (truncating divide by 4), and one res_valid is emitted per channel after the 4th sample.
  - A timeout on any of the 4 samples discards the accumulator, sets timeout_err and moves to the next channel.
- Undefined:
  - Single conversion per channel as described above; no accumulator logic is present.

Test Plan:
- Single scan:
  - Stimulus: ch_mask=8'b1000_0101, cont=0, start pulse; behavioural driver returns 12'h100+ch.
  - Required: 3 res_valid pulses with (ch,data) = (0,100), (2,102), (7,107); addr stable during each conversion; then scan_done; busy=0.
- Empty mask:
  - Stimulus: ch_mask=0, start pulse.
  - Required: busy stays 0; no conv_go, res_valid or scan_done.
- Timeout:
  - Stimulus: mask=8'h03, driver never answers channel 0.
  - Required: timeout_err=1 exactly TIMEOUT_CYC+1 clocks after that conv_go; channel 1 still converts and produces res_valid; err_clr returns timeout_err to 0.
- Continuous mode:
  - Stimulus: cont=1, mask=8'h01, SCAN_GAP=10.
  - Required: successive scan_done pulses spaced by conversion time + 10 + FIND/ISSUE overhead. Deasserting cont gives one final scan, then IDLE.
- Async reset mid-WAIT:
  - Stimulus: assert rst_n=0, then release; a late adc_conv_done arrives.
  - Required: all outputs return to 0 immediately; the late adc_conv_done produces no res_valid.
- AVG (with ADC_SCAN_AVG_EN):
  - Stimulus: channel 3 returns 100, 101, 102, 104.
  - Required: one res_valid with res_data=101.
